// File: rtl/riscv_mem_arb_pkg.sv
// Shared encodings for the fetch / load-store memory arbiter: FSM states,
// requester IDs and the legal MEM_LATENCY range.
package riscv_mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    // CNT_W must also satisfy 2**CNT_W > MEM_LATENCY
    localparam int MEM_LATENCY_MIN = 1;
    localparam int MEM_LATENCY_MAX = 15;

endpackage

// File: rtl/riscv_mem_arb_pick.sv
// Combinational winner selection between fetch (IF) and load/store (LS).
// RISCV_MEM_ARB_ROUND_ROBIN_EN: alternate on contention using the last-served pointer; default is fixed LS priority.
module riscv_mem_arb_pick
    import riscv_mem_arb_pkg::*;
(
    input  logic i_if_valid,
    input  logic i_ls_valid,
`ifdef RISCV_MEM_ARB_ROUND_ROBIN_EN
    input  logic i_last_served,
`endif
    output logic o_grant_valid,
    output logic o_grant_id
);

    always_comb begin
        o_grant_valid = i_if_valid | i_ls_valid;
        o_grant_id    = REQ_LS;
`ifdef RISCV_MEM_ARB_ROUND_ROBIN_EN
        if (i_if_valid && i_ls_valid) begin
            o_grant_id = (i_last_served == REQ_LS) ? REQ_IF : REQ_LS;
        end else if (i_if_valid) begin
            o_grant_id = REQ_IF;
        end
`else
        if (i_if_valid && !i_ls_valid) begin
            o_grant_id = REQ_IF;
        end
`endif
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port 32-bit RAM between instruction fetch and load/store.
// Optional macro RISCV_MEM_ARB_ROUND_ROBIN_EN enables round-robin arbitration.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   ST_IDLE   | waiting; winner's req_ready driven, request latched on accept
//   ST_ACCESS | RAM address/enables held MEM_LATENCY cycles, data sampled last
//   ST_RESP   | one-cycle rsp_valid to the winner, RAM interface idle
module riscv_mem_arbiter
    import riscv_mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 4
)(
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rdata,

    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_rsp_valid,
    output logic [31:0] ls_rdata,

    output logic [31:0] mem_address,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    arb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_id;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_if_rdata;
    logic [31:0]      r_ls_rdata;
    logic             r_if_rsp_valid;
    logic             r_ls_rsp_valid;
`ifdef RISCV_MEM_ARB_ROUND_ROBIN_EN
    logic             r_last_served;
`endif

    logic w_grant_valid;
    logic w_grant_id;
    logic w_idle;
    logic w_access;
    logic w_last_cycle;

    riscv_mem_arb_pick u_pick (
        .i_if_valid    (if_req_valid),
        .i_ls_valid    (ls_req_valid),
`ifdef RISCV_MEM_ARB_ROUND_ROBIN_EN
        .i_last_served (r_last_served),
`endif
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    assign w_idle       = (r_state == ST_IDLE);
    assign w_access     = (r_state == ST_ACCESS);
    assign w_last_cycle = (r_cnt == '0);

    assign if_req_ready = w_idle & if_req_valid & (w_grant_id == REQ_IF);
    assign ls_req_ready = w_idle & ls_req_valid & (w_grant_id == REQ_LS);

    // RAM interface is gated by state so it reads as all-zero outside ACCESS
    assign mem_address      = w_access ? r_addr  : '0;
    assign mem_write_data   = w_access ? r_wdata : '0;
    assign mem_read_enable  = w_access & ~r_we;
    assign mem_write_enable = w_access & r_we & w_last_cycle;

    assign if_rsp_valid = r_if_rsp_valid;
    assign ls_rsp_valid = r_ls_rsp_valid;
    assign if_rdata     = r_if_rdata;
    assign ls_rdata     = r_ls_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_id           <= REQ_LS;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_if_rdata     <= '0;
            r_ls_rdata     <= '0;
            r_if_rsp_valid <= 1'b0;
            r_ls_rsp_valid <= 1'b0;
`ifdef RISCV_MEM_ARB_ROUND_ROBIN_EN
            r_last_served  <= REQ_LS;
`endif
        end else begin
            r_if_rsp_valid <= 1'b0;
            r_ls_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_id    <= w_grant_id;
                        r_cnt   <= CNT_LOAD;
                        r_state <= ST_ACCESS;
                        if (w_grant_id == REQ_LS) begin
                            r_addr  <= ls_addr;
                            r_we    <= ls_we;
                            r_wdata <= ls_wdata;
                        end else begin
                            r_addr  <= if_addr;
                            r_we    <= 1'b0;
                            r_wdata <= '0;
                        end
`ifdef RISCV_MEM_ARB_ROUND_ROBIN_EN
                        r_last_served <= w_grant_id;
`endif
                    end
                end
                ST_ACCESS: begin
                    if (w_last_cycle) begin
                        r_state <= ST_RESP;
                        if (r_id == REQ_LS) begin
                            r_ls_rdata     <= r_we ? '0 : mem_read_data;
                            r_ls_rsp_valid <= 1'b1;
                        end else begin
                            r_if_rdata     <= mem_read_data;
                            r_if_rsp_valid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/riscv_mem_arbiter.md
Name:
riscv_mem_arbiter

Overview:
- Sequencer/arbiter that shares one single-port 32-bit data RAM between two requesters in the RISC-V core: instruction fetch (read-only) and load/store (read/write).
- Sits between the fetch/LSU logic and the RAM's address/readEnable/writeEnable/writeData/readData interface.
- Serialises accesses through a small FSM, inserts a programmable number of memory wait cycles, and returns read data with a one-cycle response strobe.

Parameters:
- MEM_LATENCY, 1, number of cycles address and enables are held before read data is sampled; legal range 1..15.
- CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > MEM_LATENCY.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- if_req_valid  input  1  fetch requests a read
- if_req_ready  output  1  fetch request accepted this cycle
- if_addr  input  32  fetch byte address
- if_rsp_valid  output  1  one-cycle strobe: if_rdata valid
- if_rdata  output  32  fetch read data
- ls_req_valid  input  1  load/store request
- ls_req_ready  output  1  load/store request accepted this cycle
- ls_we  input  1  1 = store, 0 = load
- ls_addr  input  32  load/store byte address
- ls_wdata  input  32  store data
- ls_rsp_valid  output  1  one-cycle strobe: load data valid or store complete
- ls_rdata  output  32  load read data; 0 for stores
- mem_address  output  32  RAM address
- mem_read_enable  output  1  RAM read enable
- mem_write_enable  output  1  RAM write enable
- mem_write_data  output  32  RAM write data
- mem_read_data  input  32  RAM read data; valid while address and read enable are held

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - FSM state = IDLE.
  - All outputs are 0, including both ready signals, both rsp_valid strobes, both rdata outputs and all mem_* outputs.
  - Last-served pointer = LS.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req_valid is high, pick a winner and assert that port's req_ready combinationally. The other port's ready stays 0.
  - On acceptance (valid & ready), latch the winner ID, address, we and wdata. A fetch request always latches we = 0.
  - Load counter = MEM_LATENCY-1 and go to ACCESS.
  - If no request is valid, stay in IDLE.
- ACCESS:
  - mem_address and mem_write_data are driven from the latched values.
  - mem_read_enable = !we, held for every ACCESS cycle.
  - mem_write_enable = we, asserted only on the final ACCESS cycle (counter == 0). Exactly one write pulse per store.
  - Counter decrements each cycle.
  - When counter == 0: capture mem_read_data into the winner's rdata register (0 for a store) and go to RESP.
- RESP:
  - Winner's rsp_valid = 1 for exactly one cycle. mem_* outputs = 0.
  - Always go to IDLE next. A new request is accepted no earlier than the cycle after RESP (no bypass).
- Latency: acceptance edge to rsp_valid high = MEM_LATENCY+1 cycles. Throughput is one access per MEM_LATENCY+2 cycles.
- Arbitration (default, fixed priority): LS wins over IF when both are valid.
- rdata holding: each rdata holds its value until that port's next response. The losing port's rdata is untouched.
- Request inputs after acceptance: changes to req_valid, addr or wdata after acceptance are ignored. Latched values govern the access.
- Reset mid-operation: any access is aborted. No rsp_valid is issued and the FSM returns to IDLE. A store already past its write pulse is not undone.
- Address: no alignment check or masking. The full 32-bit address is passed through unchanged.

Optional Feature:
- Macro: RISCV_MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - When both ports are valid in IDLE, the port that is not the last-served pointer wins.
  - The pointer updates on every acceptance. Reset pointer = LS, so IF wins the first contention.
  - A single valid requester always wins regardless of the pointer.
- Undefined: fixed LS-over-IF priority. The pointer register is not instantiated.

Decomposition:
- Package riscv_mem_arb_pkg holds:
  - the state encoding (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2);
  - requester ID constants (REQ_IF = 1'b0, REQ_LS = 1'b1);
  - MEM_LATENCY range limits.
- Sub-module riscv_mem_arb_pick: combinational winner selection from both valids plus the last-served pointer; contains the round-robin/fixed-priority `ifdef.
- FSM, counter and latches stay in the top module.

Test Plan:
- Reset: hold rst 2 cycles mid-ACCESS (MEM_LATENCY=3) -> all outputs 0 next cycle, no rsp_valid, FSM accepts new request next cycle.
- IF read: if_addr=0x0000_0010, RAM word=0xDEAD_BEEF, MEM_LATENCY=1 -> if_req_ready in cycle 0, mem_read_enable in cycle 1, if_rsp_valid with if_rdata=0xDEAD_BEEF in cycle 2.
- Store then load:
  - ls_we=1, ls_addr=0x20, ls_wdata=0x1234_5678, MEM_LATENCY=3 -> exactly one mem_write_enable pulse, in the third ACCESS cycle; ls_rsp_valid with ls_rdata=0.
  - Follow with a load from 0x20 -> ls_rdata=0x1234_5678.
- Contention, macro undefined: both valid continuously for 4 grants -> LS, LS, LS, LS; if_req_ready never high.
- Contention, RISCV_MEM_ARB_ROUND_ROBIN_EN defined: both valid for 4 grants -> IF, LS, IF, LS.
- Input change after acceptance: change if_addr from 0x10 to 0x40 in the cycle after acceptance -> mem_address stays 0x10 through ACCESS; if_rsp_valid pulses exactly once.
